// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared funct/opcode codes, ALU-op and forwarding encodings, MD types
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_IDLE   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_OP_OPCODE = 2'b11;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_ZERO = 2'b11;

    // ALU-internal codes that have no architectural funct of their own
    localparam logic [5:0] ADD_OP  = 6'b100000;
    localparam logic [5:0] IDLE_OP = 6'b111111;
    localparam logic [5:0] LUI_OP  = 6'b111110;

    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;
    localparam logic [5:0] FUNCT_JALR = 6'b001001;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
    localparam logic [5:0] OPCODE_JAL   = 6'b000011;
    localparam logic [5:0] OPCODE_ADDI  = 6'b001000;
    localparam logic [5:0] OPCODE_ADDIU = 6'b001001;
    localparam logic [5:0] OPCODE_SLTI  = 6'b001010;
    localparam logic [5:0] OPCODE_SLTIU = 6'b001011;
    localparam logic [5:0] OPCODE_ANDI  = 6'b001100;
    localparam logic [5:0] OPCODE_ORI   = 6'b001101;
    localparam logic [5:0] OPCODE_XORI  = 6'b001110;
    localparam logic [5:0] OPCODE_LUI   = 6'b001111;

    // Encoding matches funct[1:0] of MULT/MULTU/DIV/DIVU
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    function automatic logic [5:0] opcode_to_funct(input logic [5:0] opcode);
        case (opcode)
            OPCODE_ADDI:  return ADD_OP;
            OPCODE_ADDIU: return FUNCT_ADDU;
            OPCODE_SLTI:  return FUNCT_SLT;
            OPCODE_SLTIU: return FUNCT_SLTU;
            OPCODE_ANDI:  return FUNCT_AND;
            OPCODE_ORI:   return FUNCT_OR;
            OPCODE_XORI:  return FUNCT_XOR;
            OPCODE_LUI:   return LUI_OP;
            OPCODE_JAL:   return FUNCT_JALR;
            default:      return IDLE_OP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : Combinational integer ALU driven by a funct-space operation code
// Revision : 1.0 - initial release
// ============================================================================
module alu
    import mips_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 6
) (
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    input  logic [4:0]         i_shamt,
    input  logic [NB_OP-1:0]   i_op,
    output logic [NB_DATA-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            ADD_OP, FUNCT_ADDU:    o_result = i_a + i_b;
            FUNCT_SUB, FUNCT_SUBU: o_result = i_a - i_b;
            FUNCT_AND:  o_result = i_a & i_b;
            FUNCT_OR:   o_result = i_a | i_b;
            FUNCT_XOR:  o_result = i_a ^ i_b;
            FUNCT_NOR:  o_result = ~(i_a | i_b);
            FUNCT_SLT:  o_result = {{(NB_DATA-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            FUNCT_SLTU: o_result = {{(NB_DATA-1){1'b0}}, i_a < i_b};
            FUNCT_SLL:  o_result = i_b << i_shamt;
            FUNCT_SRL:  o_result = i_b >> i_shamt;
            FUNCT_SRA:  o_result = $signed(i_b) >>> i_shamt;
            FUNCT_SLLV: o_result = i_b << i_a[4:0];
            FUNCT_SRLV: o_result = i_b >> i_a[4:0];
            FUNCT_SRAV: o_result = $signed(i_b) >>> i_a[4:0];
            LUI_OP:     o_result = i_b << (NB_DATA/2);
            // Link instructions carry the return address in operand A
            FUNCT_JALR: o_result = i_a;
            default:    o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative radix-2 multiply / restoring divide with HI/LO registers
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic               i_start,
    input  md_op_e             i_op,
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    input  logic               i_mt_hi,
    input  logic               i_mt_lo,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo,
    output logic               o_busy
);

    localparam int                NB_CNT      = $clog2(NB_DATA);
    localparam logic [NB_CNT-1:0] C_LAST_ITER = NB_CNT'(NB_DATA-1);

    md_state_e          r_state, w_state_next;
    logic [NB_CNT-1:0]  r_count;
    logic [NB_DATA-1:0] r_upper, r_lower, r_operand, r_dividend, r_hi, r_lo;
    logic               r_is_div, r_neg_res, r_neg_rem, r_div_zero;

    logic               w_signed, w_a_neg, w_b_neg, w_last;
    logic [NB_DATA-1:0] w_a_mag, w_b_mag;
    logic [NB_DATA:0]   w_sum, w_shift, w_diff;
    logic [NB_DATA-1:0] w_iter_upper, w_iter_lower, w_fin_hi, w_fin_lo;
    logic [2*NB_DATA-1:0] w_prod, w_prod_signed;

    assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
    assign w_a_neg  = w_signed && i_a[NB_DATA-1];
    assign w_b_neg  = w_signed && i_b[NB_DATA-1];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;
    assign w_last   = (r_state == MD_BUSY) && (r_count == C_LAST_ITER);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= MD_IDLE;
        end else if (!i_halt) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MD_IDLE: if (i_start) w_state_next = MD_BUSY;
            MD_BUSY: if (w_last)  w_state_next = MD_IDLE;
            default: w_state_next = MD_IDLE;
        endcase
    end

    // Upper holds the partial product / remainder, lower the multiplier / quotient
    assign w_sum   = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_operand} : '0);
    assign w_shift = {r_upper, r_lower[NB_DATA-1]};
    assign w_diff  = w_shift - {1'b0, r_operand};

    always_comb begin
        w_iter_upper = r_upper;
        w_iter_lower = r_lower;
        if (r_is_div) begin
            if (!w_diff[NB_DATA]) begin
                w_iter_upper = w_diff[NB_DATA-1:0];
                w_iter_lower = {r_lower[NB_DATA-2:0], 1'b1};
            end else begin
                w_iter_upper = w_shift[NB_DATA-1:0];
                w_iter_lower = {r_lower[NB_DATA-2:0], 1'b0};
            end
        end else begin
            w_iter_upper = w_sum[NB_DATA:1];
            w_iter_lower = {w_sum[0], r_lower[NB_DATA-1:1]};
        end
    end

    always_comb begin
        w_prod        = {w_iter_upper, w_iter_lower};
        w_prod_signed = r_neg_res ? -w_prod : w_prod;
        w_fin_hi      = w_prod_signed[2*NB_DATA-1:NB_DATA];
        w_fin_lo      = w_prod_signed[NB_DATA-1:0];
        if (r_is_div) begin
            if (r_div_zero) begin
                w_fin_hi = r_dividend;
                w_fin_lo = '1;
            end else begin
                w_fin_hi = r_neg_rem ? -w_iter_upper : w_iter_upper;
                w_fin_lo = r_neg_res ? -w_iter_lower : w_iter_lower;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count    <= '0;
            r_upper    <= '0;
            r_lower    <= '0;
            r_operand  <= '0;
            r_dividend <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (!i_halt) begin
            if (r_state == MD_IDLE && i_start) begin
                r_count    <= '0;
                r_upper    <= '0;
                r_lower    <= w_a_mag;
                r_operand  <= w_b_mag;
                r_dividend <= i_a;
                r_is_div   <= (i_op == MD_DIV) || (i_op == MD_DIVU);
                r_neg_res  <= w_a_neg ^ w_b_neg;
                r_neg_rem  <= w_a_neg;
                r_div_zero <= (i_b == '0);
            end else if (r_state == MD_BUSY) begin
                r_upper <= w_iter_upper;
                r_lower <= w_iter_lower;
                r_count <= w_last ? '0 : r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!i_halt) begin
            if (w_last) begin
                r_hi <= w_fin_hi;
                r_lo <= w_fin_lo;
            end else if (r_state == MD_IDLE) begin
                if (i_mt_hi) r_hi <= i_a;
                if (i_mt_lo) r_lo <= i_a;
            end
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_busy = (r_state == MD_BUSY);

endmodule
`default_nettype wire

// File: rtl/instruction_execute_md.sv
`default_nettype none
// ============================================================================
// Module   : instruction_execute_md
// Brief    : EX stage with forwarding, ALU, HI/LO multiply-divide and EX/MEM reg
// Revision : 1.0 - initial release
// ============================================================================
module instruction_execute_md
    import mips_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic [NB_DATA-1:0] i_RA,
    input  logic [NB_DATA-1:0] i_RB,
    input  logic [NB_REG-1:0]  i_rs,
    input  logic [NB_REG-1:0]  i_rt,
    input  logic [NB_REG-1:0]  i_rd,
    input  logic [NB_OP-1:0]   i_funct,
    input  logic [NB_OP-1:0]   i_opcode,
    input  logic [4:0]         i_shamt,
    input  logic [NB_DATA-1:0] i_inmediato,
    input  logic               i_WB_write,
    input  logic               i_WB_mem_to_reg,
    input  logic               i_MEM_read,
    input  logic               i_MEM_write,
    input  logic               i_MEM_unsigned,
    input  logic [1:0]         i_MEM_byte_half_word,
    input  logic               i_EX_alu_src,
    input  logic               i_EX_reg_dst,
    input  logic [1:0]         i_EX_alu_op,
    input  logic [1:0]         i_corto_rs,
    input  logic [1:0]         i_corto_rt,
    input  logic [NB_DATA-1:0] i_input_ALU_MEM,
    input  logic [NB_DATA-1:0] i_output_WB,
    output logic               o_WB_write,
    output logic               o_WB_mem_to_reg,
    output logic               o_MEM_read,
    output logic               o_MEM_write,
    output logic               o_MEM_unsigned,
    output logic [1:0]         o_MEM_byte_half_word,
    output logic [NB_REG-1:0]  o_write_reg,
    output logic [NB_DATA-1:0] o_data_to_write_in_MEM,
    output logic [NB_DATA-1:0] o_ALU_result,
    output logic               o_stall,
    output logic               o_md_busy
);

    logic               w_jump_link, w_md_field, w_busy;
    logic               w_is_start, w_is_mfhi, w_is_mflo, w_is_mthi, w_is_mtlo, w_is_access;
    logic [NB_DATA-1:0] w_data_a, w_data_b, w_alu_b, w_alu_result, w_hi, w_lo, w_result;
    logic [NB_OP-1:0]   w_alu_funct;

    // A late write to $zero must never be forwarded as a live value
    function automatic logic [NB_DATA-1:0] fwd_sel(
        input logic [1:0]         sel,
        input logic [NB_REG-1:0]  idx,
        input logic [NB_DATA-1:0] reg_val,
        input logic [NB_DATA-1:0] wb_val,
        input logic [NB_DATA-1:0] mem_val
    );
        case (sel)
            FWD_WB:   return (idx == '0) ? '0 : wb_val;
            FWD_MEM:  return (idx == '0) ? '0 : mem_val;
            FWD_ZERO: return '0;
            default:  return reg_val;
        endcase
    endfunction

    assign w_jump_link = (i_opcode == OPCODE_JAL) ||
                         ((i_opcode == OPCODE_RTYPE) && (i_funct == FUNCT_JALR));
    assign w_data_a = w_jump_link ? i_RA :
                      fwd_sel(i_corto_rs, i_rs, i_RA, i_output_WB, i_input_ALU_MEM);
    assign w_data_b = w_jump_link ? i_RB :
                      fwd_sel(i_corto_rt, i_rt, i_RB, i_output_WB, i_input_ALU_MEM);
    assign w_alu_b  = i_EX_alu_src ? i_inmediato : w_data_b;

    always_comb begin
        w_alu_funct = IDLE_OP;
        case (i_EX_alu_op)
            ALU_OP_ADD:    w_alu_funct = ADD_OP;
            ALU_OP_FUNCT:  w_alu_funct = i_funct;
            ALU_OP_OPCODE: w_alu_funct = opcode_to_funct(i_opcode);
            default:       w_alu_funct = IDLE_OP;
        endcase
    end

    alu #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_alu (
        .i_a      (w_data_a),
        .i_b      (w_alu_b),
        .i_shamt  (i_shamt),
        .i_op     (w_alu_funct),
        .o_result (w_alu_result)
    );

    assign w_md_field  = (i_EX_alu_op == ALU_OP_FUNCT);
    assign w_is_start  = w_md_field && ((i_funct == FUNCT_MULT) || (i_funct == FUNCT_MULTU) ||
                                        (i_funct == FUNCT_DIV)  || (i_funct == FUNCT_DIVU));
    assign w_is_mfhi   = w_md_field && (i_funct == FUNCT_MFHI);
    assign w_is_mflo   = w_md_field && (i_funct == FUNCT_MFLO);
    assign w_is_mthi   = w_md_field && (i_funct == FUNCT_MTHI);
    assign w_is_mtlo   = w_md_field && (i_funct == FUNCT_MTLO);
    assign w_is_access = w_is_mfhi || w_is_mflo || w_is_mthi || w_is_mtlo;

    assign o_stall   = w_busy && (w_is_start || w_is_access);
    assign o_md_busy = w_busy;

    mult_div_unit #(
        .NB_DATA (NB_DATA)
    ) u_mult_div_unit (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_halt  (i_halt),
        .i_start (w_is_start && !o_stall),
        .i_op    (md_op_e'(i_funct[1:0])),
        .i_a     (w_data_a),
        .i_b     (w_data_b),
        .i_mt_hi (w_is_mthi && !o_stall),
        .i_mt_lo (w_is_mtlo && !o_stall),
        .o_hi    (w_hi),
        .o_lo    (w_lo),
        .o_busy  (w_busy)
    );

    assign w_result = w_is_mfhi ? w_hi : (w_is_mflo ? w_lo : w_alu_result);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_WB_write             <= 1'b0;
            o_WB_mem_to_reg        <= 1'b0;
            o_MEM_read             <= 1'b0;
            o_MEM_write            <= 1'b0;
            o_MEM_unsigned         <= 1'b0;
            o_MEM_byte_half_word   <= '0;
            o_write_reg            <= '0;
            o_data_to_write_in_MEM <= '0;
            o_ALU_result           <= '0;
        end else if (!i_halt) begin
            if (o_stall) begin
                o_WB_write             <= 1'b0;
                o_WB_mem_to_reg        <= 1'b0;
                o_MEM_read             <= 1'b0;
                o_MEM_write            <= 1'b0;
                o_MEM_unsigned         <= 1'b0;
                o_MEM_byte_half_word   <= '0;
                o_write_reg            <= '0;
                o_data_to_write_in_MEM <= '0;
                o_ALU_result           <= '0;
            end else begin
                o_WB_write             <= i_WB_write;
                o_WB_mem_to_reg        <= i_WB_mem_to_reg;
                o_MEM_read             <= i_MEM_read;
                o_MEM_write            <= i_MEM_write;
                o_MEM_unsigned         <= i_MEM_unsigned;
                o_MEM_byte_half_word   <= i_MEM_byte_half_word;
                o_write_reg            <= i_EX_reg_dst ? i_rd : i_rt;
                o_data_to_write_in_MEM <= w_data_b;
                o_ALU_result           <= w_result;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_execute_md.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_execute_md
// Brief    : Directed self-checking bench for the EX stage with multiply-divide
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_instruction_execute_md;
    import mips_pkg::*;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int NB_OP   = 6;

    logic               i_clk = 1'b0;
    logic               i_reset, i_halt;
    logic [NB_DATA-1:0] i_RA, i_RB, i_inmediato, i_input_ALU_MEM, i_output_WB;
    logic [NB_REG-1:0]  i_rs, i_rt, i_rd;
    logic [NB_OP-1:0]   i_funct, i_opcode;
    logic [4:0]         i_shamt;
    logic               i_WB_write, i_WB_mem_to_reg, i_MEM_read, i_MEM_write, i_MEM_unsigned;
    logic [1:0]         i_MEM_byte_half_word, i_EX_alu_op, i_corto_rs, i_corto_rt;
    logic               i_EX_alu_src, i_EX_reg_dst;
    logic               o_WB_write, o_WB_mem_to_reg, o_MEM_read, o_MEM_write, o_MEM_unsigned;
    logic [1:0]         o_MEM_byte_half_word;
    logic [NB_REG-1:0]  o_write_reg;
    logic [NB_DATA-1:0] o_data_to_write_in_MEM, o_ALU_result;
    logic               o_stall, o_md_busy;

    int n_checks = 0;
    int n_pass   = 0;

    instruction_execute_md #(
        .NB_DATA (NB_DATA),
        .NB_REG  (NB_REG),
        .NB_OP   (NB_OP)
    ) dut (
        .i_clk                  (i_clk),
        .i_reset                (i_reset),
        .i_halt                 (i_halt),
        .i_RA                   (i_RA),
        .i_RB                   (i_RB),
        .i_rs                   (i_rs),
        .i_rt                   (i_rt),
        .i_rd                   (i_rd),
        .i_funct                (i_funct),
        .i_opcode               (i_opcode),
        .i_shamt                (i_shamt),
        .i_inmediato            (i_inmediato),
        .i_WB_write             (i_WB_write),
        .i_WB_mem_to_reg        (i_WB_mem_to_reg),
        .i_MEM_read             (i_MEM_read),
        .i_MEM_write            (i_MEM_write),
        .i_MEM_unsigned         (i_MEM_unsigned),
        .i_MEM_byte_half_word   (i_MEM_byte_half_word),
        .i_EX_alu_src           (i_EX_alu_src),
        .i_EX_reg_dst           (i_EX_reg_dst),
        .i_EX_alu_op            (i_EX_alu_op),
        .i_corto_rs             (i_corto_rs),
        .i_corto_rt             (i_corto_rt),
        .i_input_ALU_MEM        (i_input_ALU_MEM),
        .i_output_WB            (i_output_WB),
        .o_WB_write             (o_WB_write),
        .o_WB_mem_to_reg        (o_WB_mem_to_reg),
        .o_MEM_read             (o_MEM_read),
        .o_MEM_write            (o_MEM_write),
        .o_MEM_unsigned         (o_MEM_unsigned),
        .o_MEM_byte_half_word   (o_MEM_byte_half_word),
        .o_write_reg            (o_write_reg),
        .o_data_to_write_in_MEM (o_data_to_write_in_MEM),
        .o_ALU_result           (o_ALU_result),
        .o_stall                (o_stall),
        .o_md_busy              (o_md_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_nop;
        i_RA = '0; i_RB = '0; i_rs = 5'd1; i_rt = 5'd2; i_rd = '0;
        i_funct = '0; i_opcode = '0; i_shamt = '0; i_inmediato = '0;
        i_WB_write = 0; i_WB_mem_to_reg = 0; i_MEM_read = 0; i_MEM_write = 0;
        i_MEM_unsigned = 0; i_MEM_byte_half_word = 2'b00;
        i_EX_alu_src = 0; i_EX_reg_dst = 0; i_EX_alu_op = ALU_OP_IDLE;
        i_corto_rs = FWD_REG; i_corto_rt = FWD_REG;
    endtask

    task automatic set_r(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
        set_nop;
        i_EX_alu_op = ALU_OP_FUNCT;
        i_funct = funct;
        i_RA = a;
        i_RB = b;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (o_md_busy && n < 200) begin
            tick;
            n++;
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        set_r(FUNCT_MFHI, 32'h0, 32'h0);
        i_WB_write = 1; i_EX_reg_dst = 1; i_rd = 5'd2;
        #1 check({tag, "_nostall"}, 32'(o_stall), 32'd0);
        tick;
        check({tag, "_hi"}, o_ALU_result, exp_hi);
        check({tag, "_wreg"}, 32'(o_write_reg), 32'd2);
        i_funct = FUNCT_MFLO;
        tick;
        check({tag, "_lo"}, o_ALU_result, exp_lo);
        set_nop;
    endtask

    task automatic run_md(input string tag, input logic [5:0] funct, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        set_r(funct, a, b);
        tick;
        set_nop;
        wait_idle(n);
        check({tag, "_busy_cycles"}, 32'(n), 32'd32);
        read_hilo(tag, exp_hi, exp_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int stalls;
        int bubble_bad;

        set_nop;
        i_halt = 0;
        i_reset = 1;
        i_input_ALU_MEM = '0;
        i_output_WB = '0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 0;
        check("rst_result", o_ALU_result, 32'h0);
        check("rst_ctrl", {24'h0, o_WB_write, o_WB_mem_to_reg, o_MEM_read, o_MEM_write,
                           o_MEM_unsigned, o_MEM_byte_half_word, o_md_busy}, 32'h0);
        check("rst_wreg_data", {27'h0, o_write_reg} | o_data_to_write_in_MEM, 32'h0);

        // Store: address add with immediate, rt forwarded from WB
        set_nop;
        i_EX_alu_op = ALU_OP_ADD; i_EX_alu_src = 1; i_RA = 32'd100; i_inmediato = 32'd4;
        i_corto_rt = FWD_WB; i_output_WB = 32'hAB; i_MEM_write = 1;
        i_MEM_byte_half_word = 2'b10; i_rt = 5'd7;
        tick;
        check("sw_addr", o_ALU_result, 32'd104);
        check("sw_data", o_data_to_write_in_MEM, 32'hAB);
        check("sw_ctrl", {29'h0, o_MEM_write, o_MEM_byte_half_word}, 32'h6);
        check("sw_wreg", 32'(o_write_reg), 32'd7);

        set_nop;
        i_EX_alu_op = ALU_OP_OPCODE; i_opcode = OPCODE_ORI; i_EX_alu_src = 1;
        i_RA = 32'hF0; i_inmediato = 32'h0F;
        tick;
        check("ori", o_ALU_result, 32'hFF);

        set_r(FUNCT_SUB, 32'd99, 32'd1);
        i_corto_rs = FWD_ZERO;
        tick;
        check("sub_zero_fwd", o_ALU_result, 32'hFFFFFFFF);

        set_nop;
        i_EX_alu_op = ALU_OP_OPCODE; i_opcode = OPCODE_JAL; i_RA = 32'h400;
        i_corto_rs = FWD_MEM; i_input_ALU_MEM = 32'd5;
        tick;
        check("jal_bypass", o_ALU_result, 32'h400);

        run_md("mult", FUNCT_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);

        // MFLO arriving one cycle after the MULTU's first busy cycle
        set_r(FUNCT_MULTU, 32'hFFFFFFFF, 32'd2);
        tick;
        set_nop;
        tick;
        set_r(FUNCT_MFLO, 32'h0, 32'h0);
        i_WB_write = 1; i_EX_reg_dst = 1; i_rd = 5'd9;
        #1 check("mflo_stall_on", 32'(o_stall), 32'd1);
        stalls = 0;
        bubble_bad = 0;
        while (o_stall && stalls < 100) begin
            tick;
            stalls++;
            if (o_WB_write !== 1'b0 || o_write_reg !== '0) bubble_bad++;
        end
        check("mflo_stall_cycles", 32'(stalls), 32'd31);
        check("mflo_bubbles", 32'(bubble_bad), 32'd0);
        tick;
        check("multu_lo", o_ALU_result, 32'hFFFFFFFE);
        check("multu_lo_ctrl", {26'h0, o_WB_write, o_write_reg}, 32'h29);
        set_r(FUNCT_MFHI, 32'h0, 32'h0);
        tick;
        check("multu_hi", o_ALU_result, 32'h1);

        // Independent ADD while DIV iterates
        set_r(FUNCT_DIV, 32'hFFFFFFF9, 32'd2);
        tick;
        set_r(ADD_OP, 32'h0, 32'd10);
        i_corto_rs = FWD_MEM; i_input_ALU_MEM = 32'd5;
        #1 check("add_nostall", 32'(o_stall), 32'd0);
        tick;
        check("add_fwd_mem", o_ALU_result, 32'd15);
        set_nop;
        wait_idle(n);
        check("div_busy_rest", 32'(n), 32'd31);
        read_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

        run_md("divu0", FUNCT_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
        run_md("divovf", FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

        set_r(FUNCT_MTHI, 32'hDEAD, 32'h0);
        i_corto_rs = FWD_WB; i_output_WB = 32'h1234;
        tick;
        set_r(FUNCT_MTLO, 32'hBEEF, 32'h0);
        i_corto_rs = FWD_MEM; i_input_ALU_MEM = 32'h5678;
        tick;
        read_hilo("mt", 32'h1234, 32'h5678);

        // Halt for 10 cycles in the middle of a DIVU
        set_r(FUNCT_DIVU, 32'd100, 32'd7);
        tick;
        set_nop;
        n = 0;
        repeat (5) begin tick; n++; end
        i_halt = 1;
        set_r(FUNCT_MFLO, 32'h0, 32'h0);
        #1 check("halt_stall_comb", 32'(o_stall), 32'd1);
        repeat (10) begin tick; n++; end
        check("halt_result_hold", o_ALU_result, 32'h0);
        check("halt_busy_hold", 32'(o_md_busy), 32'd1);
        i_halt = 0;
        set_nop;
        while (o_md_busy && n < 200) begin tick; n++; end
        check("halt_busy_cycles", 32'(n), 32'd42);
        read_hilo("divu_halt", 32'd2, 32'd14);

        // Asynchronous reset in the middle of a MULT
        set_r(FUNCT_MULT, 32'd5, 32'd6);
        tick;
        set_r(ADD_OP, 32'd3, 32'd4);
        i_WB_write = 1;
        tick;
        check("pre_rst_add", o_ALU_result, 32'd7);
        set_nop;
        repeat (2) tick;
        #2 i_reset = 1;
        #1;
        check("async_rst_busy", 32'(o_md_busy), 32'd0);
        check("async_rst_out", {o_ALU_result[30:0], o_WB_write}, 32'h0);
        #1 i_reset = 0;
        tick;
        read_hilo("post_rst", 32'h0, 32'h0);

        // Start and reset together: reset wins
        i_reset = 1;
        set_r(FUNCT_MULT, 32'd5, 32'd6);
        tick;
        i_reset = 0;
        set_nop;
        tick;
        check("rst_beats_start", 32'(o_md_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
